// File: rtl/constraint_sampler_ctrl.sv
// Draws LFSR candidate pairs until one satisfies "A == 0 or B != 0", then offers it over valid/ready.
// Optional saturating statistics counters are enabled by defining SAMPLER_STATS_EN.
module constraint_sampler_ctrl #(
    parameter int unsigned A_W       = 12,
    parameter int unsigned B_W       = 6,
    parameter int unsigned MAX_TRIES = 1024,
    parameter logic [31:0] SEED      = 32'hACE1_2468,
    localparam int unsigned TW       = $clog2(MAX_TRIES + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           seed_load,
    input  logic [31:0]    seed_in,
    output logic           busy,
    output logic           sol_valid,
    input  logic           sol_ready,
    output logic [A_W-1:0] sol_a,
    output logic [B_W-1:0] sol_b,
    output logic           fail,
    output logic [TW-1:0]  tries,
    output logic [15:0]    stat_pass,
    output logic [15:0]    stat_reject
);

    typedef enum logic [1:0] {IDLE, GEN, CHECK, HOLD} state_t;

    state_t         state_q, state_d;
    logic [31:0]    lfsr_q, lfsr_step;
    logic [A_W-1:0] cand_a_q;
    logic [B_W-1:0] cand_b_q;
    logic           pass;
    logic           budget_done;

    assign lfsr_step   = {1'b0, lfsr_q[31:1]} ^ ({32{lfsr_q[0]}} & 32'h8020_0003);
    // -A is zero mod 2^A_W exactly when A is zero, so no negation is needed.
    assign pass        = (cand_a_q == '0) || (cand_b_q != '0);
    assign budget_done = (tries == TW'(MAX_TRIES));
    assign busy        = (state_q != IDLE);
    assign sol_valid   = (state_q == HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = GEN;
            GEN:   state_d = CHECK;
            CHECK: begin
                if (pass)             state_d = HOLD;
                else if (budget_done) state_d = IDLE;
                else                  state_d = GEN;
            end
            HOLD:  if (sol_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q   <= SEED;
            cand_a_q <= '0;
            cand_b_q <= '0;
            sol_a    <= '0;
            sol_b    <= '0;
            fail     <= 1'b0;
            tries    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Seed load lands before GEN, so a same-cycle start uses the new seed.
                    if (seed_load) lfsr_q <= (seed_in == '0) ? SEED : seed_in;
                    if (start) begin
                        tries <= '0;
                        fail  <= 1'b0;
                    end
                end
                GEN: begin
                    cand_a_q <= lfsr_q[A_W-1:0];
                    cand_b_q <= lfsr_q[A_W+B_W-1:A_W];
                    lfsr_q   <= lfsr_step;
                    tries    <= tries + TW'(1);
                end
                CHECK: begin
                    if (pass) begin
                        sol_a <= cand_a_q;
                        sol_b <= cand_b_q;
                    end else if (budget_done) begin
                        fail <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SAMPLER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_pass   <= '0;
            stat_reject <= '0;
        end else begin
            if (state_q == HOLD && sol_ready && stat_pass != 16'hFFFF)
                stat_pass <= stat_pass + 16'd1;
            if (state_q == CHECK && !pass && stat_reject != 16'hFFFF)
                stat_reject <= stat_reject + 16'd1;
        end
    end
`else
    assign stat_pass   = '0;
    assign stat_reject = '0;
`endif

endmodule

// File: tb/tb_constraint_sampler_ctrl.sv
// Randomized self-checking bench for constraint_sampler_ctrl against a high-level sampling model.
// Statistics expectations follow SAMPLER_STATS_EN when defined.
module tb_constraint_sampler_ctrl;

    localparam int unsigned MT = 8;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic clk = 1'b0;
    logic rst;
    logic start, seed_load, sol_ready;
    logic [31:0] seed_in;
    logic busy, sol_valid, fail;
    logic [11:0] sol_a;
    logic [5:0]  sol_b;
    logic [3:0]  tries;
    logic [15:0] stat_pass, stat_reject;

    logic s1_start, s1_seed_load, s1_sol_ready;
    logic [31:0] s1_seed_in;
    logic s1_busy, s1_sol_valid, s1_fail;
    logic [11:0] s1_sol_a;
    logic [5:0]  s1_sol_b;
    logic [0:0]  s1_tries;
    logic [15:0] s1_stat_pass, s1_stat_reject;

    int checks = 0;
    int passes = 0;
    logic [31:0] mlfsr;
    int exp_sp = 0;
    int exp_sr = 0;

    always #5 clk = ~clk;

    constraint_sampler_ctrl #(.A_W(12), .B_W(6), .MAX_TRIES(MT), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .seed_load(seed_load), .seed_in(seed_in),
        .busy(busy), .sol_valid(sol_valid), .sol_ready(sol_ready), .sol_a(sol_a), .sol_b(sol_b),
        .fail(fail), .tries(tries), .stat_pass(stat_pass), .stat_reject(stat_reject));

    constraint_sampler_ctrl #(.A_W(12), .B_W(6), .MAX_TRIES(1), .SEED(SEED)) dut1 (
        .clk(clk), .rst(rst), .start(s1_start), .seed_load(s1_seed_load), .seed_in(s1_seed_in),
        .busy(s1_busy), .sol_valid(s1_sol_valid), .sol_ready(s1_sol_ready), .sol_a(s1_sol_a),
        .sol_b(s1_sol_b), .fail(s1_fail), .tries(s1_tries), .stat_pass(s1_stat_pass),
        .stat_reject(s1_stat_reject));

    function automatic logic [31:0] next_lfsr(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Draw candidates until one satisfies the implication or the budget runs out.
    task automatic model_run(input int max, inout logic [31:0] l, output int n, output bit ok,
                             output int a, output int b);
        n = 0; ok = 0; a = 0; b = 0;
        while (n < max && !ok) begin
            a = int'(l & 32'hFFF);
            b = int'((l >> 12) & 32'h3F);
            l = next_lfsr(l);
            n++;
            if (a == 0 || b != 0) ok = 1;
        end
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic check_stats;
        int sp, sr;
`ifdef SAMPLER_STATS_EN
        sp = exp_sp; sr = exp_sr;
`else
        sp = 0; sr = 0;
`endif
        checks++;
        if (stat_pass !== 16'(sp)) $display("FAIL stat_pass: got %0d expected %0d", stat_pass, sp);
        else passes++;
        checks++;
        if (stat_reject !== 16'(sr)) $display("FAIL stat_reject: got %0d expected %0d", stat_reject, sr);
        else passes++;
    endtask

    // One full run on the main instance; poke exercises ignored inputs during HOLD and IDLE.
    task automatic run_main(input bit ld, input logic [31:0] sd, input int hold_cycles, input bit poke);
        int n, ea, eb, c;
        bit ok;
        if (ld) mlfsr = (sd == 0) ? SEED : sd;
        model_run(MT, mlfsr, n, ok, ea, eb);
        start = 1; seed_load = ld; seed_in = sd;
        tick();
        start = 0; seed_load = 0;
        c = 1;
        while (!(sol_valid || fail) && c < 60) begin tick(); c++; end
        checks++;
        if (c != 2 * n + 1) $display("FAIL latency: got cycle %0d expected %0d", c, 2 * n + 1);
        else passes++;
        checks++;
        if (tries !== 4'(n)) $display("FAIL tries: got %0d expected %0d", tries, n);
        else passes++;
        if (ok) begin
            checks++;
            if (sol_valid !== 1'b1 || fail !== 1'b0 || sol_a !== 12'(ea) || sol_b !== 6'(eb))
                $display("FAIL solution: got v=%0b f=%0b a=%0h b=%0h expected v=1 f=0 a=%0h b=%0h",
                         sol_valid, fail, sol_a, sol_b, ea, eb);
            else passes++;
            for (int h = 0; h < hold_cycles; h++) begin
                if (poke && h == 0) begin start = 1; seed_load = 1; seed_in = $urandom | 32'h1; end
                tick();
                start = 0; seed_load = 0;
                checks++;
                if (sol_valid !== 1'b1 || busy !== 1'b1 || sol_a !== 12'(ea) || sol_b !== 6'(eb))
                    $display("FAIL hold_stable: got v=%0b busy=%0b a=%0h b=%0h expected v=1 busy=1 a=%0h b=%0h",
                             sol_valid, busy, sol_a, sol_b, ea, eb);
                else passes++;
            end
            sol_ready = 1;
            tick();
            sol_ready = 0;
            exp_sp++;
            exp_sr += n - 1;
            checks++;
            if (busy !== 1'b0 || sol_valid !== 1'b0 || sol_a !== 12'(ea) || sol_b !== 6'(eb))
                $display("FAIL handshake: got busy=%0b v=%0b a=%0h b=%0h expected busy=0 v=0 a=%0h b=%0h",
                         busy, sol_valid, sol_a, sol_b, ea, eb);
            else passes++;
        end else begin
            exp_sr += n;
            checks++;
            if (fail !== 1'b1 || busy !== 1'b0 || sol_valid !== 1'b0)
                $display("FAIL exhaust_main: got fail=%0b busy=%0b v=%0b expected fail=1 busy=0 v=0",
                         fail, busy, sol_valid);
            else passes++;
        end
        if (poke) begin
            sol_ready = 1;
            tick();
            sol_ready = 0;
            checks++;
            if (busy !== 1'b0 || sol_valid !== 1'b0)
                $display("FAIL idle_ready: got busy=%0b v=%0b expected 0 0", busy, sol_valid);
            else passes++;
        end
        check_stats();
    endtask

    task automatic test_reset;
        rst = 1;
        tick(); tick();
        checks++;
        if ({busy, sol_valid, fail, sol_a, sol_b, tries, stat_pass, stat_reject} !== '0)
            $display("FAIL reset_values: got busy=%0b v=%0b f=%0b a=%0h b=%0h t=%0d sp=%0d sr=%0d expected all 0",
                     busy, sol_valid, fail, sol_a, sol_b, tries, stat_pass, stat_reject);
        else passes++;
        rst = 0;
        tick();
        start = 1;
        tick();
        start = 0;
        checks++;
        if (busy !== 1'b1) $display("FAIL gen_busy: got %0b expected 1", busy);
        else passes++;
        #2 rst = 1;
        #1;
        checks++;
        if (busy !== 1'b0 || sol_valid !== 1'b0 || fail !== 1'b0 || tries !== 4'd0)
            $display("FAIL async_reset: got busy=%0b v=%0b f=%0b t=%0d expected 0 0 0 0",
                     busy, sol_valid, fail, tries);
        else passes++;
        tick();
        rst = 0;
        mlfsr = SEED; exp_sp = 0; exp_sr = 0;
        tick();
        run_main(0, 32'h0, 1, 0);
        checks++;
        if (sol_a !== 12'h468 || sol_b !== 6'h12)
            $display("FAIL seed_first: got a=%0h b=%0h expected a=468 b=12", sol_a, sol_b);
        else passes++;
    endtask

    task automatic test_immediate_pass;
        run_main(1, 32'h0000_1000, 5, 0);
        checks++;
        if (sol_a !== 12'h000 || sol_b !== 6'h01 || tries !== 4'd1)
            $display("FAIL imm_pass: got a=%0h b=%0h t=%0d expected a=0 b=1 t=1", sol_a, sol_b, tries);
        else passes++;
    endtask

    task automatic test_nonzero_pass;
        run_main(1, 32'h0000_3007, 0, 0);
        checks++;
        if (sol_a !== 12'h007 || sol_b !== 6'h03 || tries !== 4'd1)
            $display("FAIL nz_pass: got a=%0h b=%0h t=%0d expected a=7 b=3 t=1", sol_a, sol_b, tries);
        else passes++;
    endtask

    task automatic test_exhaustion;
        int c;
        bit seen_valid;
        s1_start = 1; s1_seed_load = 1; s1_seed_in = 32'h0000_0005;
        tick();
        s1_start = 0; s1_seed_load = 0;
        seen_valid = 0;
        for (c = 1; c < 3; c++) begin
            if (s1_sol_valid || s1_fail || !s1_busy) seen_valid = 1;
            tick();
        end
        checks++;
        if (seen_valid) $display("FAIL exhaust_early: got early valid/fail/idle expected busy run");
        else passes++;
        checks++;
        if (s1_fail !== 1'b1 || s1_busy !== 1'b0 || s1_tries !== 1'b1 || s1_sol_valid !== 1'b0)
            $display("FAIL exhaust: got fail=%0b busy=%0b t=%0d v=%0b expected 1 0 1 0",
                     s1_fail, s1_busy, s1_tries, s1_sol_valid);
        else passes++;
        tick();
        checks++;
        if (s1_fail !== 1'b1) $display("FAIL fail_sticky: got %0b expected 1", s1_fail);
        else passes++;
        s1_start = 1; s1_seed_load = 1; s1_seed_in = 32'h0000_1000;
        tick();
        s1_start = 0; s1_seed_load = 0;
        checks++;
        if (s1_fail !== 1'b0 || s1_busy !== 1'b1)
            $display("FAIL fail_clear: got fail=%0b busy=%0b expected 0 1", s1_fail, s1_busy);
        else passes++;
        c = 1;
        while (!s1_sol_valid && c < 10) begin tick(); c++; end
        checks++;
        if (c != 3 || s1_sol_a !== 12'h000 || s1_sol_b !== 6'h01)
            $display("FAIL s1_pass: got cycle=%0d a=%0h b=%0h expected 3 0 1", c, s1_sol_a, s1_sol_b);
        else passes++;
        s1_sol_ready = 1;
        tick();
        s1_sol_ready = 0;
    endtask

    task automatic test_zero_seed_ignored;
        run_main(1, 32'h0, 3, 1);
        run_main(0, 32'h0, 0, 0);
    endtask

    task automatic test_random;
        logic [31:0] sd;
        for (int i = 0; i < 24; i++) begin
            sd = $urandom;
            if ($urandom_range(0, 1) == 1) sd = sd & 32'hFF00_0FFF;
            run_main(($urandom_range(0, 3) != 0), sd, $urandom_range(0, 2), 0);
        end
    endtask

    initial begin
        rst = 1; start = 0; seed_load = 0; seed_in = '0; sol_ready = 0;
        s1_start = 0; s1_seed_load = 0; s1_seed_in = '0; s1_sol_ready = 0;
        test_reset();
        test_immediate_pass();
        test_nonzero_pass();
        test_exhaustion();
        test_zero_seed_ignored();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
